lstm_bp_cell: RTL

Backward-pass (BPTT) counterpart of the LSTM forward cell. It takes the cached forward activations of one time step and the incoming gradients, and produces the four gate deltas plus the cell-state gradient passed to step t-1. All arithmetic runs through one shared saturating fixed-point multiplier, sequenced by an FSM over 16 cycles. It sits between the forward-activation cache and the weight-gradient accumulators.

---
 rtl/lstm_bp_pkg.sv | 35 +++
 rtl/lstm_bp_cell_mul.sv | 33 +++
 rtl/lstm_bp_cell.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/lstm_bp_pkg.sv
// Shared constants, types and saturating helpers for the LSTM backward-pass cell.
// Contents: word width and fraction bits, ONE, FSM state encoding, step counter
// type, and the sat_add / sat_sub functions (WIDTH+1-bit result clamped to WIDTH).
package lstm_bp_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned FRAC  = 24;

   typedef logic signed [WIDTH-1:0] word_t;

   localparam word_t ONE    = word_t'(1) << FRAC;
   localparam word_t MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
   localparam word_t MinVal = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   typedef logic [3:0] step_t;
   localparam step_t LastStep = 4'd15;

   function automatic word_t sat_add(input word_t x, input word_t y);
      logic [WIDTH:0] s;
      s = {x[WIDTH-1], x} + {y[WIDTH-1], y};
      // Top two bits differ only when the sum left the WIDTH-bit range
      if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? MinVal : MaxVal;
      return s[WIDTH-1:0];
   endfunction

   function automatic word_t sat_sub(input word_t x, input word_t y);
      logic [WIDTH:0] s;
      s = {x[WIDTH-1], x} - {y[WIDTH-1], y};
      if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? MinVal : MaxVal;
      return s[WIDTH-1:0];
   endfunction

endpackage

// File: rtl/lstm_bp_cell_mul.sv
// fxp_mul_sat: combinational signed fixed-point multiply.
// Full 2*WIDTH product, arithmetic shift right by FRAC (floor), saturate to WIDTH.
// Ports: a, b  operands; p  saturated result.
module fxp_mul_sat #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FRAC  = 24
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] p
);

   logic signed [2*WIDTH-1:0] ax;
   logic signed [2*WIDTH-1:0] bx;
   logic signed [2*WIDTH-1:0] prod;
   logic signed [2*WIDTH-1:0] sh;
   logic        [WIDTH:0]     hi;

   assign ax   = {{WIDTH{a[WIDTH-1]}}, a};
   assign bx   = {{WIDTH{b[WIDTH-1]}}, b};
   assign prod = ax * bx;
   assign sh   = prod >>> FRAC;
   // Result fits when every bit above the WIDTH-bit sign position matches it
   assign hi   = sh[2*WIDTH-1:WIDTH-1];

   always_comb begin
      p = sh[WIDTH-1:0];
      if (!(&hi) && |hi) begin
         p = sh[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

endmodule

// File: rtl/lstm_bp_cell.sv
// lstm_bp_cell: LSTM backward-pass cell for one time step.
// Captures cached forward values and incoming gradients on i_start, then runs a
// 16-step schedule through a single saturating multiplier to produce the gate
// deltas (o_da, o_di, o_df, o_do) and the cell-state gradient o_dc.
// Ports: clk, rst (async, active-high); i_start; i_a/i_i/i_f/i_o/i_tc/i_cp/i_dh/
// i_dcn/i_fn data in; o_busy, o_valid (1-cycle pulse); o_dc..o_do results.
module lstm_bp_cell
   import lstm_bp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_i,
   input  logic [WIDTH-1:0] i_f,
   input  logic [WIDTH-1:0] i_o,
   input  logic [WIDTH-1:0] i_tc,
   input  logic [WIDTH-1:0] i_cp,
   input  logic [WIDTH-1:0] i_dh,
   input  logic [WIDTH-1:0] i_dcn,
   input  logic [WIDTH-1:0] i_fn,
   output logic             o_busy,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_dc,
   output logic [WIDTH-1:0] o_da,
   output logic [WIDTH-1:0] o_di,
   output logic [WIDTH-1:0] o_df,
   output logic [WIDTH-1:0] o_do
);

   state_e state_q, state_d;
   step_t  step_q, step_d;
   logic   capture, finish, valid_q;

   word_t a_q, i_q, f_q, o_q, tc_q, cp_q, dh_q, dcn_q, fn_q;
   word_t r0_q, dc_q, da_q, di_q, df_q;
   word_t op_x, op_y, prod;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      capture = 1'b0;
      finish  = 1'b0;
      case (state_q)
         StIdle: begin
            if (i_start) begin
               state_d = StCalc;
               step_d  = '0;
               capture = 1'b1;
            end
         end
         StCalc: begin
            step_d = step_q + 4'd1;
            if (step_q == LastStep) begin
               state_d = StDone;
               finish  = 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Operand select for the shared multiplier, one product per step
   always_comb begin
      op_x = '0;
      op_y = '0;
      case (step_q)
         4'd0:  begin op_x = tc_q;  op_y = tc_q;                 end
         4'd1:  begin op_x = o_q;   op_y = sat_sub(ONE, r0_q);   end
         4'd2:  begin op_x = dh_q;  op_y = r0_q;                 end
         4'd3:  begin op_x = dcn_q; op_y = fn_q;                 end
         4'd4:  begin op_x = a_q;   op_y = a_q;                  end
         4'd5:  begin op_x = i_q;   op_y = sat_sub(ONE, r0_q);   end
         4'd6:  begin op_x = dc_q;  op_y = r0_q;                 end
         4'd7:  begin op_x = i_q;   op_y = sat_sub(ONE, i_q);    end
         4'd8:  begin op_x = a_q;   op_y = r0_q;                 end
         4'd9:  begin op_x = dc_q;  op_y = r0_q;                 end
         4'd10: begin op_x = f_q;   op_y = sat_sub(ONE, f_q);    end
         4'd11: begin op_x = cp_q;  op_y = r0_q;                 end
         4'd12: begin op_x = dc_q;  op_y = r0_q;                 end
         4'd13: begin op_x = o_q;   op_y = sat_sub(ONE, o_q);    end
         4'd14: begin op_x = tc_q;  op_y = r0_q;                 end
         4'd15: begin op_x = dh_q;  op_y = r0_q;                 end
         default: ;
      endcase
   end

   fxp_mul_sat #(
      .WIDTH(WIDTH),
      .FRAC (FRAC)
   ) u_mul (
      .a(op_x),
      .b(op_y),
      .p(prod)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         step_q  <= '0;
         valid_q <= 1'b0;
         a_q     <= '0;
         i_q     <= '0;
         f_q     <= '0;
         o_q     <= '0;
         tc_q    <= '0;
         cp_q    <= '0;
         dh_q    <= '0;
         dcn_q   <= '0;
         fn_q    <= '0;
         r0_q    <= '0;
         dc_q    <= '0;
         da_q    <= '0;
         di_q    <= '0;
         df_q    <= '0;
         o_dc    <= '0;
         o_da    <= '0;
         o_di    <= '0;
         o_df    <= '0;
         o_do    <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         valid_q <= finish;
         if (capture) begin
            a_q   <= i_a;
            i_q   <= i_i;
            f_q   <= i_f;
            o_q   <= i_o;
            tc_q  <= i_tc;
            cp_q  <= i_cp;
            dh_q  <= i_dh;
            dcn_q <= i_dcn;
            fn_q  <= i_fn;
         end
         if (state_q == StCalc) begin
            case (step_q)
               4'd3:    dc_q <= sat_add(r0_q, prod);
               4'd6:    da_q <= prod;
               4'd9:    di_q <= prod;
               4'd12:   df_q <= prod;
               4'd15:   ;
               default: r0_q <= prod;
            endcase
         end
         // The final product goes straight to o_do so all outputs change together
         if (finish) begin
            o_dc <= dc_q;
            o_da <= da_q;
            o_di <= di_q;
            o_df <= df_q;
            o_do <= prod;
         end
      end
   end

   assign o_busy  = (state_q != StIdle);
   assign o_valid = valid_q;

endmodule
